pcpi_calc_sequencer: RTL
========================

PCPI_CALC_SEQUENCER -- requirements
Module: pcpi_calc_sequencer

Interface
REQ-001 Parameter NUM_ADD_CLK, default 4, SHALL set the clock cycles spent per adder stage (legal 1..15).
REQ-002 Parameter NUM_ADDER_STAGES, default 6, SHALL set the number of adder-tree stages sequenced per output (legal 1..8).
REQ-003 Parameter DOWNSAMPLE, default 4, SHALL set the control words consumed per output sample (legal 1..255).
REQ-004 Ports SHALL be:
  clk  in  1  single clock, all logic on rising edge
  resetn  in  1  synchronous, active-low reset
  pcpi_valid  in  1  CPU co-processor instruction valid
  pcpi_insn  in  32  instruction word
  pcpi_rs1  in  32  control-bit word
  pcpi_rs2  in  32  unused, ignored
  pcpi_wr  out  1  write rd this response
  pcpi_rd  out  32  result to CPU
  pcpi_wait  out  1  co-processor busy
  pcpi_ready  out  1  instruction complete
  dp_bits  out  32  latched control word to estimator
  dp_load  out  1  one-cycle load strobe for dp_bits
  dp_clear  out  1  one-cycle accumulator clear, coincident with dp_load
  dp_stage_en  out  1  adder stage active
  dp_stage  out  3  current adder stage index
  dp_result  in  32  estimator output sample
  busy  out  1  state != IDLE

Function
REQ-005 Decode: match SHALL be (pcpi_insn & 32'hfe00707f) == 32'h00002027; other instructions SHALL be ignored with no output change.
REQ-006 FSM states SHALL be IDLE, LOAD, ADD, RESP, DRAIN; one-hot or binary encoding is free.
REQ-007 IDLE -> LOAD when pcpi_valid & match; pcpi_rs1 latched into dp_bits on that edge.
REQ-008 LOAD (1 cycle): dp_load=1; dp_clear=1 iff ds_cnt==0; next ADD if ds_cnt==DOWNSAMPLE-1 (final), else RESP.
REQ-009 ADD: dp_stage_en=1; clk_cnt counts 0..NUM_ADD_CLK-1; at terminal count dp_stage increments, clk_cnt returns to 0; after stage NUM_ADDER_STAGES-1 terminal count -> RESP with pcpi_rd <= dp_result sampled that edge.
REQ-010 RESP (1 cycle): pcpi_ready=1, pcpi_wait=0; pcpi_wr=1 and pcpi_rd=sampled result if final, else pcpi_wr=0, pcpi_rd=0; ds_cnt <= final ? 0 : ds_cnt+1; next DRAIN.
REQ-011 DRAIN (1 cycle): pcpi_valid ignored (CPU still holding it); next IDLE.
REQ-012 pcpi_wait SHALL be 1 exactly in LOAD and ADD.
REQ-013 Latency from accept edge T: non-final pcpi_ready at T+2; final at T+2+NUM_ADDER_STAGES*NUM_ADD_CLK (T+26 at defaults).
REQ-014 Abort: pcpi_valid=0 in LOAD or ADD SHALL return to IDLE next edge, no RESP, ds_cnt unchanged, dp_stage and clk_cnt cleared.
REQ-015 ds_cnt SHALL be 8-bit and change only in RESP; it wraps to 0 after DOWNSAMPLE-1, never exceeds DOWNSAMPLE-1.
REQ-016 dp_load, dp_clear, pcpi_ready SHALL be single-cycle pulses; dp_stage SHALL be 0 outside ADD.

Reset
REQ-017 resetn=0 at a rising edge SHALL force IDLE, ds_cnt=0, clk_cnt=0 and all outputs to 0 (dp_bits, pcpi_rd included), overriding any in-flight instruction with no response.
REQ-018 First accept after reset release SHALL be treated as ds_cnt==0 (dp_clear asserted).

Verification
REQ-019 Defaults, 4 matching instructions rs1=1,2,3,4, dp_result=32'h00ABCDEF: first three -> pcpi_ready at T+2, pcpi_wr=0; fourth -> ready at T+26, pcpi_wr=1, pcpi_rd=32'h00ABCDEF; dp_clear only on first.
REQ-020 Non-matching insn 32'h00000033 with pcpi_valid=1 for 20 cycles -> busy, pcpi_wait, pcpi_ready stay 0.
REQ-021 Final instruction, drop pcpi_valid at ADD cycle 5 -> IDLE next edge, no pcpi_ready; next instruction is again final (ready at T+26).
REQ-022 Assert resetn=0 during ADD stage 3 -> next edge all outputs 0, IDLE; following instruction asserts dp_clear.
REQ-023 Hold pcpi_valid with match through RESP and one more cycle -> no re-accept in DRAIN; exactly one pcpi_ready pulse.
REQ-024 DOWNSAMPLE=1, NUM_ADD_CLK=1, NUM_ADDER_STAGES=1 -> every instruction final, dp_clear every load, pcpi_ready at T+3.

Source files
------------

// File: rtl/pcpi_calc_sequencer.sv
// PCPI co-processor sequencer for the estimator datapath: accepts one custom
// instruction at a time, hands its control word to the estimator and, on
// every DOWNSAMPLE-th word, steps the adder tree before returning a sample.
module pcpi_calc_sequencer #(
  parameter int NUM_ADD_CLK      = 4,
  parameter int NUM_ADDER_STAGES = 6,
  parameter int DOWNSAMPLE       = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic [31:0] dp_bits,
  output logic        dp_load,
  output logic        dp_clear,
  output logic        dp_stage_en,
  output logic [2:0]  dp_stage,
  input  logic [31:0] dp_result,
  output logic        busy
);

  localparam logic [3:0] CLK_LAST   = 4'(NUM_ADD_CLK - 1);
  localparam logic [2:0] STAGE_LAST = 3'(NUM_ADDER_STAGES - 1);
  localparam logic [7:0] DS_LAST    = 8'(DOWNSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ADD   = 3'd2,
    S_RESP  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  clk_cnt;
  logic [2:0]  stage_cnt;
  logic [7:0]  ds_cnt;
  logic [31:0] bits_q;
  logic [31:0] rd_q;

  logic insn_match;
  logic accept;
  logic is_final;
  logic add_tc;
  logic add_done;
  logic unused_rs2;

  assign insn_match = (pcpi_insn & 32'hfe00707f) == 32'h00002027;
  assign accept     = (state == S_IDLE) && pcpi_valid && insn_match;
  // ds_cnt is constant from LOAD through RESP, so this flag is stable for
  // the whole transaction and selects both the ADD path and the write-back.
  assign is_final   = ds_cnt >= DS_LAST;
  assign add_tc     = clk_cnt == CLK_LAST;
  assign add_done   = (state == S_ADD) && pcpi_valid && add_tc &&
                      (stage_cnt == STAGE_LAST);
  assign unused_rs2 = ^pcpi_rs2;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; a dropped pcpi_valid while busy aborts back to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_LOAD;
      S_LOAD: begin
        if (!pcpi_valid)   state_nxt = S_IDLE;
        else if (is_final) state_nxt = S_ADD;
        else               state_nxt = S_RESP;
      end
      S_ADD: begin
        if (!pcpi_valid)   state_nxt = S_IDLE;
        else if (add_done) state_nxt = S_RESP;
      end
      S_RESP:  state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    pcpi_wait   = (state == S_LOAD) || (state == S_ADD);
    pcpi_ready  = state == S_RESP;
    pcpi_wr     = (state == S_RESP) && is_final;
    pcpi_rd     = ((state == S_RESP) && is_final) ? rd_q : 32'h0;
    dp_load     = state == S_LOAD;
    dp_clear    = (state == S_LOAD) && (ds_cnt == 8'd0);
    dp_stage_en = state == S_ADD;
    dp_stage    = (state == S_ADD) ? stage_cnt : 3'd0;
    busy        = state != S_IDLE;
    dp_bits     = bits_q;
  end

  // Adder-tree sequencing: clock counter per stage, stage index per output
  always_ff @(posedge clk) begin
    if (!resetn) begin
      clk_cnt   <= 4'd0;
      stage_cnt <= 3'd0;
    end else if ((state == S_ADD) && pcpi_valid) begin
      if (add_tc) begin
        clk_cnt   <= 4'd0;
        stage_cnt <= (stage_cnt == STAGE_LAST) ? 3'd0 : stage_cnt + 3'd1;
      end else begin
        clk_cnt <= clk_cnt + 4'd1;
      end
    end else begin
      clk_cnt   <= 4'd0;
      stage_cnt <= 3'd0;
    end
  end

  // Downsample counter advances only on a completed response
  always_ff @(posedge clk) begin
    if (!resetn)               ds_cnt <= 8'd0;
    else if (state == S_RESP)  ds_cnt <= is_final ? 8'd0 : ds_cnt + 8'd1;
  end

  // Control word capture on accept, estimator sample capture at end of ADD
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bits_q <= 32'h0;
      rd_q   <= 32'h0;
    end else begin
      if (accept)   bits_q <= pcpi_rs1;
      if (add_done) rd_q   <= dp_result;
    end
  end

endmodule
